// File: rtl/tunnel_painter_pkg.sv
// Shared definitions for the tunnel painter: palette encodings and pipeline latency.
package tunnel_painter_pkg;

    typedef enum logic [1:0] {
        MODE_RINGS    = 2'd0,
        MODE_GRADIENT = 2'd1,
        MODE_SECTORS  = 2'd2,
        MODE_OFF      = 2'd3
    } mode_t;

    // Pixel-in to rgb-out latency: |d| stage, square stage, sum stage,
    // COORD_W square-root stages, colour stage.
    function automatic int lat_of(input int coord_w);
        return coord_w + 4;
    endfunction

endpackage

// File: rtl/pipe_isqrt.sv
// Pipelined restoring integer square root: root = floor(sqrt(din)), with a valid
// bit and a side-data word carried alongside. OUT_W-1 register stages; the first
// stage resolves the two most significant root bits, every later stage one bit.
module pipe_isqrt #(
    parameter int IN_W   = 13,
    parameter int SIDE_W = 1,
    parameter int OUT_W  = (IN_W + 1) / 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   din,
    input  logic [SIDE_W-1:0] side_in,
    output logic              out_valid,
    output logic [OUT_W-1:0]  root,
    output logic [SIDE_W-1:0] side_out
);

    localparam int STAGES = OUT_W - 1;
    localparam int PAD_W  = 2 * OUT_W;
    localparam int REM_W  = OUT_W + 2;

    // One restoring iteration: bring down a bit pair, try subtracting 4*root+1.
    // Returns {remainder, root}.
    function automatic logic [REM_W+OUT_W-1:0] sq_step(
        input logic [REM_W-1:0] rem,
        input logic [OUT_W-1:0] rt,
        input logic [1:0]       pair
    );
        logic [REM_W-1:0] acc;
        logic [REM_W-1:0] trial;
        acc   = {rem[REM_W-3:0], pair};
        trial = {rt, 2'b01};
        if (acc >= trial) return {acc - trial, rt[OUT_W-2:0], 1'b1};
        else              return {acc, rt[OUT_W-2:0], 1'b0};
    endfunction

    logic [PAD_W-1:0]         dpad;
    logic [REM_W+OUT_W-1:0]   head;
    logic [REM_W+OUT_W-1:0]   nxt    [STAGES];
    logic [REM_W-1:0]         rem_q  [STAGES];
    logic [OUT_W-1:0]         rt_q   [STAGES];
    logic [PAD_W-1:0]         val_q  [STAGES];
    logic [SIDE_W-1:0]        side_q [STAGES];
    logic                     vld_q  [STAGES];

    assign dpad = PAD_W'(din);

    // Next remainder/root for every stage from the previous stage's registers.
    always_comb begin
        nxt = '{default: '0};
        head = sq_step('0, '0, dpad[PAD_W-1 -: 2]);
        nxt[0] = sq_step(head[OUT_W +: REM_W], head[OUT_W-1:0], dpad[PAD_W-3 -: 2]);
        for (int s = 1; s < STAGES; s++) begin
            nxt[s] = sq_step(rem_q[s-1], rt_q[s-1], val_q[s-1][2*(OUT_W-2-s) +: 2]);
        end
    end

    // Valid shift chain; cleared on reset so in-flight data is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) vld_q[s] <= 1'b0;
        end else begin
            vld_q[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) vld_q[s] <= vld_q[s-1];
        end
    end

    // Datapath registers; qualified by the valid chain, so no reset needed.
    always_ff @(posedge clk) begin
        rem_q[0]  <= nxt[0][OUT_W +: REM_W];
        rt_q[0]   <= nxt[0][OUT_W-1:0];
        val_q[0]  <= dpad;
        side_q[0] <= side_in;
        for (int s = 1; s < STAGES; s++) begin
            rem_q[s]  <= nxt[s][OUT_W +: REM_W];
            rt_q[s]   <= nxt[s][OUT_W-1:0];
            val_q[s]  <= val_q[s-1];
            side_q[s] <= side_q[s-1];
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign root      = rt_q[STAGES-1];
    assign side_out  = side_q[STAGES-1];

endmodule

// File: rtl/tunnel_painter.sv
// Tunnel effect pixel shader: distance from a (optionally drifting) centre,
// square root, animated phase, palette, and PWM compare against the subframe.
module tunnel_painter
    import tunnel_painter_pkg::*;
#(
    parameter int COORD_W     = 6,
    parameter int BPC         = 4,
    parameter int SPEED_SHIFT = 2,
    parameter int DRIFT       = 1,
    parameter int MARGIN      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         frame,
    input  logic [7:0]         subframe,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               in_valid,
    input  logic [1:0]         mode,
    output logic [2:0]         rgb,
    output logic               out_valid
);

    localparam int SQ_W  = 2 * COORD_W;
    localparam int R2_W  = SQ_W + 1;
    localparam int R_W   = COORD_W + 1;
    localparam int PSH   = (BPC <= 5) ? 5 - BPC : 0;
    localparam logic [COORD_W-1:0] CENTRE = COORD_W'(1 << (COORD_W - 1));
    localparam logic [COORD_W-1:0] LO     = COORD_W'(MARGIN);
    localparam logic [COORD_W-1:0] HI     = COORD_W'((1 << COORD_W) - 1 - MARGIN);

    // Frame-edge sampled control and centre state.
    logic [9:0]         frame_q;
    mode_t              mode_q;
    logic [COORD_W-1:0] cx, cy, nx, ny;
    logic               vx_neg, vy_neg;
    logic               frame_edge;

    assign frame_edge = (frame != frame_q);
    assign nx = vx_neg ? cx - COORD_W'(1) : cx + COORD_W'(1);
    assign ny = vy_neg ? cy - COORD_W'(1) : cy + COORD_W'(1);

    // Latch mode/frame and step the centre only when the frame number changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= frame;
            mode_q  <= MODE_RINGS;
            cx      <= CENTRE;
            cy      <= CENTRE;
            vx_neg  <= 1'b0;
            vy_neg  <= 1'b0;
        end else if (frame_edge) begin
            frame_q <= frame;
            mode_q  <= mode_t'(mode);
            if (DRIFT != 0) begin
                cx <= nx;
                cy <= ny;
                if (nx == LO || nx == HI) vx_neg <= ~vx_neg;
                if (ny == LO || ny == HI) vy_neg <= ~vy_neg;
            end
        end
    end

    // Stages 1-3: absolute distances, squares, sum of squares.
    logic               v1, v2, v3;
    logic [COORD_W-1:0] dx, dy;
    logic [SQ_W-1:0]    sqx, sqy;
    logic [R2_W-1:0]    r2;
    logic [BPC-1:0]     sub1, sub2, sub3;

    // Valid bits of the front stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Front-stage datapath; the centre used is the one registered before this cycle.
    always_ff @(posedge clk) begin
        dx   <= (cx > x) ? cx - x : x - cx;
        dy   <= (cy > y) ? cy - y : y - cy;
        sub1 <= subframe[BPC-1:0];
        sqx  <= SQ_W'(dx) * SQ_W'(dx);
        sqy  <= SQ_W'(dy) * SQ_W'(dy);
        sub2 <= sub1;
        r2   <= R2_W'(sqx) + R2_W'(sqy);
        sub3 <= sub2;
    end

    logic           vs;
    logic [R_W-1:0] r;
    logic [BPC-1:0] subs;

    pipe_isqrt #(
        .IN_W   (R2_W),
        .SIDE_W (BPC),
        .OUT_W  (R_W)
    ) u_isqrt (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v3),
        .din       (r2),
        .side_in   (sub3),
        .out_valid (vs),
        .root      (r),
        .side_out  (subs)
    );

    // Colour stage: animated phase and palette intensities.
    logic [4:0]     phase;
    logic [BPC-1:0] ir, ig, ib;

    // Palette lookup from the phase under the currently active mode.
    always_comb begin
        phase = 5'(r) - frame_q[SPEED_SHIFT +: 5];
        ir = '0;
        ig = '0;
        ib = '0;
        case (mode_q)
            MODE_RINGS: begin
                if (phase == 5'h1F)     ir = '1;
                if (phase[1:0] == 2'b11) ib = '1;
            end
            MODE_GRADIENT: begin
                ir = BPC'(phase >> PSH);
                ib = ~ir;
            end
            MODE_SECTORS: begin
                case (phase[4:3])
                    2'd0:    ir = '1;
                    2'd1:    ig = '1;
                    2'd2:    ib = '1;
                    default: begin
                        ir = '1;
                        ig = '1;
                        ib = '1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Output register: PWM compare, forced dark when not valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            rgb       <= 3'b000;
        end else begin
            out_valid <= vs;
            rgb       <= vs ? {ir > subs, ig > subs, ib > subs} : 3'b000;
        end
    end

    logic unused_sub;
    assign unused_sub = ^(subframe >> BPC);

endmodule

// File: tb/tb_tunnel_painter.sv
// Directed bench for tunnel_painter: vector table, full-panel sqrt sweeps,
// mode/frame timing sequences, reset flush, and centre drift on a second instance.
module tb_tunnel_painter;
    import tunnel_painter_pkg::*;

    localparam int CW  = 6;
    localparam int LAT = lat_of(CW);

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    frame, frame_d;
    logic [7:0]    subframe;
    logic [CW-1:0] x, y;
    logic          in_valid, in_valid_d;
    logic [1:0]    mode;
    logic [2:0]    rgb, rgb_d;
    logic          out_valid, out_valid_d;

    tunnel_painter #(.COORD_W(CW), .BPC(4), .SPEED_SHIFT(2), .DRIFT(0), .MARGIN(8)) dut (
        .clk(clk), .reset(reset), .frame(frame), .subframe(subframe), .x(x), .y(y),
        .in_valid(in_valid), .mode(mode), .rgb(rgb), .out_valid(out_valid)
    );

    tunnel_painter #(.COORD_W(CW), .BPC(4), .SPEED_SHIFT(2), .DRIFT(1), .MARGIN(8)) dut_d (
        .clk(clk), .reset(reset), .frame(frame_d), .subframe(subframe), .x(x), .y(y),
        .in_valid(in_valid_d), .mode(mode), .rgb(rgb_d), .out_valid(out_valid_d)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_q[$];
    int         t_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid output pops one expectation and its issue cycle.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected out_valid", 1, 0);
            end else begin
                check("rgb", int'(rgb), int'(exp_q.pop_front()));
                check("latency", cyc - t_q.pop_front(), LAT);
            end
        end else begin
            check("rgb idle", int'(rgb), 0);
        end
    end

    // Independent reference: centre fixed at (32,32), SPEED_SHIFT=2, BPC=4.
    function automatic logic [2:0] model(input int px, input int py, input int m,
                                         input int f, input int sub);
        int ddx, ddy, rr2, rr, ph, s, ir, ig, ib, sec;
        ddx = (px > 32) ? px - 32 : 32 - px;
        ddy = (py > 32) ? py - 32 : 32 - py;
        rr2 = ddx * ddx + ddy * ddy;
        rr  = 0;
        while ((rr + 1) * (rr + 1) <= rr2) rr++;
        ph = (rr - ((f / 4) % 32) + 64) % 32;
        s  = sub % 16;
        ir = 0; ig = 0; ib = 0;
        if (m == 0) begin
            ir = (ph == 31) ? 15 : 0;
            ib = (ph % 4 == 3) ? 15 : 0;
        end else if (m == 1) begin
            ir = ph / 2;
            ib = 15 - ir;
        end else if (m == 2) begin
            sec = ph / 8;
            ir = (sec == 0 || sec == 3) ? 15 : 0;
            ig = (sec == 1 || sec == 3) ? 15 : 0;
            ib = (sec == 2 || sec == 3) ? 15 : 0;
        end
        return {ir > s, ig > s, ib > s};
    endfunction

    // Driver tasks; inputs change 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Force a frame edge so the requested mode/frame become active.
    task automatic set_ctrl(input int m, input int f);
        mode  = 2'(m);
        frame = frame ^ 10'h200;
        tick(1);
        frame = 10'(f);
        tick(2);
    endtask

    task automatic send(input int px, input int py, input int sub, input logic [2:0] e);
        x        = CW'(px);
        y        = CW'(py);
        subframe = 8'(sub);
        in_valid = 1'b1;
        exp_q.push_back(e);
        t_q.push_back(cyc);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 20 && exp_q.size() > 0; i++) tick(1);
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        t_q.delete();
        tick(2);
    endtask

    typedef struct {
        int x; int y; int m; int f; int s;
        logic [2:0] e;
    } vec_t;
    vec_t vecs[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ecx, v;
        vecs[0]  = '{32, 32, 0, 0,  0,    3'b000};  // r=0
        vecs[1]  = '{32,  1, 0, 0,  3,    3'b101};  // r=31 phase 31
        vecs[2]  = '{32,  1, 0, 4,  3,    3'b000};  // phase 30
        vecs[3]  = '{35, 36, 1, 0,  2,    3'b001};  // r=5: Ir=2 Ib=13
        vecs[4]  = '{ 0,  0, 1, 0,  8,    3'b001};  // r=45: Ir=6 Ib=9
        vecs[5]  = '{32, 16, 1, 0,  7,    3'b100};  // r=16: Ir=8 Ib=7
        vecs[6]  = '{32, 16, 2, 0,  0,    3'b001};  // sector 2
        vecs[7]  = '{32, 24, 2, 0,  0,    3'b010};  // sector 1
        vecs[8]  = '{32, 32, 2, 0, 14,    3'b100};  // sector 0, 15 > 14
        vecs[9]  = '{32, 32, 2, 0, 15,    3'b000};  // 15 > 15 is false
        vecs[10] = '{32,  8, 2, 0,  0,    3'b111};  // sector 3
        vecs[11] = '{32,  8, 3, 0,  0,    3'b000};  // mode off
        vecs[12] = '{32, 29, 0, 0,  0,    3'b001};  // r=3 phase 3
        vecs[13] = '{32, 29, 0, 16, 0,    3'b101};  // phase 3-4 wraps to 31
        vecs[14] = '{32,  1, 0, 0,  8'hF3, 3'b101}; // upper subframe bits ignored
        vecs[15] = '{32, 16, 1, 8,  7,    3'b001};  // phase 14: Ir=7 Ib=8

        // Reset state.
        reset = 1'b1; in_valid = 1'b0; in_valid_d = 1'b0;
        frame = '0; frame_d = '0; mode = '0; subframe = '0; x = '0; y = '0;
        tick(3);
        check("reset out_valid", int'(out_valid), 0);
        check("reset rgb", int'(rgb), 0);
        check("reset cx", int'(dut_d.cx), 32);
        check("reset cy", int'(dut_d.cy), 32);
        reset = 1'b0;
        tick(2);

        // Centre drift over 30 frame edges.
        ecx = 32; v = 1;
        for (int e = 1; e <= 30; e++) begin
            frame_d = frame_d + 10'd1;
            tick(1);
            ecx = ecx + v;
            if (ecx == 8 || ecx == 55) v = -v;
            check("drift cx", int'(dut_d.cx), ecx);
            check("drift cy", int'(dut_d.cy), ecx);
        end

        // Single pulse: exactly one output, LAT later, dark.
        set_ctrl(0, 0);
        send(32, 32, 0, 3'b000);
        drain();

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            set_ctrl(vecs[i].m, vecs[i].f);
            send(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].e);
            drain();
        end

        // Full-panel streams, back to back, two palettes.
        set_ctrl(1, 0);
        for (int py = 0; py < 64; py++)
            for (int px = 0; px < 64; px++)
                send(px, py, (px * 7 + py * 3) % 16, model(px, py, 1, 0, (px * 7 + py * 3) % 16));
        drain();
        set_ctrl(2, 20);
        for (int py = 0; py < 64; py++)
            for (int px = 0; px < 64; px++)
                send(px, py, (px + py) % 16, model(px, py, 2, 20, (px + py) % 16));
        drain();

        // Mode change without a frame edge has no effect until the next edge.
        set_ctrl(1, 0);
        send(32, 16, 7, 3'b100);
        mode = 2'd2;
        tick(3);
        send(32, 16, 7, 3'b100);
        drain();
        frame = 10'd1;
        tick(2);
        send(32, 16, 7, 3'b001);
        drain();

        // In-flight pixel picks up the mode active when it reaches the colour stage.
        set_ctrl(1, 0);
        send(32, 16, 7, 3'b001);
        tick(2);
        mode  = 2'd2;
        frame = 10'd2;
        drain();

        // Reset mid-stream discards everything in flight.
        set_ctrl(0, 0);
        for (int i = 0; i < 5; i++) send(32, 1, 3, 3'b101);
        reset = 1'b1;
        tick(1);
        exp_q.delete();
        t_q.delete();
        check("out_valid after reset", int'(out_valid), 0);
        reset = 1'b0;
        tick(LAT + 5);
        check("no stale outputs", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
